// File: rtl/serial_adder_controller_pkg.sv
// rtl/serial_adder_controller_pkg.sv - shared state encodings and default width for the bit-serial adder
package serial_adder_controller_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - single-bit full adder slice built from two half adders and an OR
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  // the two half-adder carries can never both be high, so OR equals majority
  assign cout = c0 | c1;

endmodule

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_controller.sv
// rtl/serial_adder_controller.sv - bit-serial WIDTH-bit adder, LSB first; SERIAL_ADDER_SUB_EN adds subtract mode
module serial_adder_controller
  import serial_adder_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             s_bit;
  logic             c_bit;

`ifdef SERIAL_ADDER_SUB_EN
  // subtraction is a + ~b + 1; the forced carry replaces cin entirely
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub | cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  full_adder_bit u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  // FSM, operand shifters, carry flop and counter; sum/cout only load on the final RUN edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b_in;
            carry  <= cin_in;
            sum_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          carry  <= c_bit;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= {s_bit, sum_sh[WIDTH-1:1]};
            cout  <= c_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder_controller.md
Name: serial_adder_controller

Overview:
- Bit-serial N-bit adder controller.
- Time-multiplexes one single-bit full-adder slice, built from two half adders plus an OR gate, over WIDTH clock cycles, LSB first.
- Start/done handshake; the result is held until the next accepted start.
- Sits between a lab-level operand source (switches or testbench) and result display or register logic. It trades WIDTH cycles of latency for a single adder bit slice.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; latched on the accepted start.
- b  in  WIDTH  operand B; latched on the accepted start.
- cin  in  1  carry-in; latched on the accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  registered result.
- cout  out  1  registered final carry.

Behaviour:
- Reset is synchronous, active-high, and overrides everything:
  - state = IDLE;
  - busy, done, cout = 0;
  - sum = 0;
  - operand shift registers, carry flop and bit counter = 0.
- Reset mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 at edge E0 latches a→A_sh, b→B_sh, cin→carry, counter=0, and moves to RUN.
  - start=0 keeps IDLE; sum and cout hold their previous values.
- RUN, at each edge:
  - slice computes s = A_sh[0]^B_sh[0]^carry and c = majority(A_sh[0], B_sh[0], carry);
  - A_sh and B_sh shift right by 1;
  - sum_sh shifts right with s entering at the MSB;
  - carry = c, counter += 1.
- RUN exit: on the edge where counter == WIDTH-1 (edge E_WIDTH), the state moves to DONE and sum = final sum_sh, cout = c.
- sum and cout are updated only on that edge, never with partial values.
- DONE: done=1, busy=0 for exactly one cycle, then unconditional return to IDLE.
- Timing:
  - start is ignored in RUN and DONE, with no queuing;
  - back-to-back throughput is one operation per WIDTH+2 cycles;
  - done is high in the cycle after edge E_WIDTH, i.e. WIDTH edges after the accepted start.
- a, b and cin may change freely after E0 without affecting the result.
- Counter width is $clog2(WIDTH).
- Arithmetic is modulo 2^WIDTH, and cout is the true carry out of the MSB.
- Simultaneous reset and start: reset wins.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - adds input port sub (1 bit), latched on the accepted start;
  - sub=1 latches ~b and forces carry=1, ignoring cin, so the result is a−b in two's complement;
  - cout = 1 means no borrow;
  - sub=0 behaves exactly like the base block.
- When undefined: the sub port is absent and behaviour is addition only.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH constant.
- One sub-module, full_adder_bit (a, b, cin → s, cout):
  - structural, two half-adder instances plus an OR for carry;
  - instantiated once in the controller.
- The controller contains the FSM, counter, shift registers and carry flop.

Test Plan:
- Reset mid-RUN: reset asserted 3 cycles into RUN → next cycle state=IDLE, busy=0, sum=0x00, cout=0, no done pulse. Then start 0x01+0x01 → sum=0x02.
- Basic add, WIDTH=8: a=0x5A, b=0x3C, cin=0, start pulse → busy for 8 cycles, done pulses 8 edges after start, sum=0x96, cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1.
- Start ignored while busy: second start with a=0x11, b=0x22 issued mid-RUN of 0x03+0x04 → single done pulse, sum=0x07. Operands changed after E0 have no effect on the result.
- Back-to-back: start held high continuously → operations accepted every 10 cycles; done pulses are exactly one cycle wide; sum stable between pulses.
- SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 → sum=0x0F, cout=1. Then a=0x01, b=0x02 → sum=0xFF, cout=0.
